// File: rtl/lut3d_dbuf_fetch.sv
// lut3d_dbuf_fetch
// Double-buffered 3D-LUT neighbour fetch. For each of PPC pixels per clock it
// returns the 8 lattice corners around an (r,g,b) grid index, read from the
// active bank. A second (shadow) bank is loaded over the config port while
// video streams. The swap to the new bank happens on the first start-of-frame
// beat after the load completes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_valid, i_sof  lookup beat valid / start-of-frame (qualified by i_valid)
//   i_idx_r/g/b     per-pixel grid index, pixel p at [p*IDX_BIT +: IDX_BIT]
//   o_valid, o_nbr  corner data, 2 cycles after the lookup beat; corner k of
//                   pixel p at [(p*8+k)*3*LUT_CD +: 3*LUT_CD], entry {B,G,R}
//   i_cfg_*         LUT load stream (raster order, r fastest), valid/ready
//   o_cfg_ready     low while a loaded LUT waits for its swap
//   o_cfg_err       sticky load error, cleared by i_cfg_err_clr
//   o_cfg_pending   complete shadow LUT waiting for the swap
//   o_active_bank   bank currently used for lookups
module lut3d_dbuf_fetch #(
  parameter int GS      = 33,
  parameter int LUT_CD  = 10,
  parameter int PPC     = 2,
  localparam int IDX_BIT = $clog2(GS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic [PPC*IDX_BIT-1:0]    i_idx_r,
  input  logic [PPC*IDX_BIT-1:0]    i_idx_g,
  input  logic [PPC*IDX_BIT-1:0]    i_idx_b,
  output logic                      o_valid,
  output logic [PPC*8*LUT_CD*3-1:0] o_nbr,
  input  logic [3*LUT_CD-1:0]       i_cfg_data,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic                      i_cfg_last,
  input  logic                      i_cfg_err_clr,
  output logic                      o_cfg_err,
  output logic                      o_cfg_pending,
  output logic                      o_active_bank
);

  localparam int EW    = 3 * LUT_CD;
  localparam int DEPTH = GS * GS * GS;
  // DEPTH is odd and greater than 1, so AW bits can also hold the value DEPTH,
  // which the load counter uses to flag a beat past the end of the table.
  localparam int AW    = $clog2(DEPTH);

  localparam logic [IDX_BIT-1:0] IDX_MAX   = IDX_BIT'(GS - 1);
  localparam logic [AW-1:0]      LAST_BEAT = AW'(DEPTH - 1);
  localparam logic [AW-1:0]      BEAT_OVF  = AW'(DEPTH);

  if (GS < 5 || GS > 65 || ((GS - 1) & (GS - 2)) != 0) begin : g_bad_gs
    $error("lut3d_dbuf_fetch: GS must be 5..65 with GS-1 a power of two");
  end
  if (PPC < 1 || PPC > 4) begin : g_bad_ppc
    $error("lut3d_dbuf_fetch: PPC must be 1..4");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Saturate a grid coordinate (one bit wider, so idx+1 cannot wrap) at GS-1.
  function automatic logic [IDX_BIT-1:0] clamp_idx(input logic [IDX_BIT:0] v);
    if (v > {1'b0, IDX_MAX}) begin
      clamp_idx = IDX_MAX;
    end else begin
      clamp_idx = v[IDX_BIT-1:0];
    end
  endfunction

  // Raster address of an entry: r fastest, then g, then b.
  function automatic logic [AW-1:0] lut_addr(input logic [IDX_BIT-1:0] r,
                                             input logic [IDX_BIT-1:0] g,
                                             input logic [IDX_BIT-1:0] b);
    lut_addr = AW'(b) * AW'(GS * GS) + AW'(g) * AW'(GS) + AW'(r);
  endfunction

  // Two banks of GS^3 entries; contents are not reset.
  logic [EW-1:0]      mem_r [2][DEPTH];

  state_t             state_r;
  state_t             state_nxt_s;
  logic [AW-1:0]      cfg_cnt_r;
  logic [AW-1:0]      cnt_nxt_s;
  logic               cfg_acc_s;
  logic               we_s;
  logic               err_set_s;
  logic               commit_s;
  logic               swap_s;

  // lo = clamped index, hi = clamped index+1; axis 0=r, 1=g, 2=b
  logic [IDX_BIT-1:0] lo_s     [PPC][3];
  logic [IDX_BIT-1:0] hi_s     [PPC][3];
  logic [AW-1:0]      addr_s   [PPC][8];
  logic [AW-1:0]      s1_addr_r[PPC][8];
  logic               s1_valid_r;
  logic               s1_bank_r;
  logic [PPC*8*EW-1:0] rd_s;

  // Clamp each pixel's input index and its +1 neighbour on every axis.
  always_comb begin
    for (int p = 0; p < PPC; p++) begin
      lo_s[p][0] = clamp_idx({1'b0, i_idx_r[p*IDX_BIT +: IDX_BIT]});
      lo_s[p][1] = clamp_idx({1'b0, i_idx_g[p*IDX_BIT +: IDX_BIT]});
      lo_s[p][2] = clamp_idx({1'b0, i_idx_b[p*IDX_BIT +: IDX_BIT]});
      hi_s[p][0] = clamp_idx({1'b0, i_idx_r[p*IDX_BIT +: IDX_BIT]} + (IDX_BIT+1)'(1));
      hi_s[p][1] = clamp_idx({1'b0, i_idx_g[p*IDX_BIT +: IDX_BIT]} + (IDX_BIT+1)'(1));
      hi_s[p][2] = clamp_idx({1'b0, i_idx_b[p*IDX_BIT +: IDX_BIT]} + (IDX_BIT+1)'(1));
    end
  end

  // Corner k selects +1 on r/g/b by bits k[0]/k[1]/k[2].
  always_comb begin
    for (int p = 0; p < PPC; p++) begin
      for (int k = 0; k < 8; k++) begin
        addr_s[p][k] = lut_addr(k[0] ? hi_s[p][0] : lo_s[p][0],
                                k[1] ? hi_s[p][1] : lo_s[p][1],
                                k[2] ? hi_s[p][2] : lo_s[p][2]);
      end
    end
  end

  // Stage 1: register corner addresses every cycle, plus valid and read bank.
  // The swap beat already reads the new bank, hence the XOR with swap_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_bank_r  <= 1'b0;
      for (int p = 0; p < PPC; p++) begin
        for (int k = 0; k < 8; k++) begin
          s1_addr_r[p][k] <= '0;
        end
      end
    end else begin
      s1_valid_r <= i_valid;
      s1_bank_r  <= o_active_bank ^ swap_s;
      for (int p = 0; p < PPC; p++) begin
        for (int k = 0; k < 8; k++) begin
          s1_addr_r[p][k] <= addr_s[p][k];
        end
      end
    end
  end

  // Read all 8*PPC corners from the selected bank in parallel.
  always_comb begin
    rd_s = '0;
    for (int p = 0; p < PPC; p++) begin
      for (int k = 0; k < 8; k++) begin
        rd_s[(p*8+k)*EW +: EW] = mem_r[s1_bank_r][s1_addr_r[p][k]];
      end
    end
  end

  // Stage 2: output register; data holds while no valid beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_nbr   <= '0;
    end else begin
      o_valid <= s1_valid_r;
      if (s1_valid_r) begin
        o_nbr <= rd_s;
      end
    end
  end

  // Config write into the shadow (inactive) bank.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[~o_active_bank][cfg_cnt_r] <= i_cfg_data;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Load FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (err_set_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cfg_acc_s) begin
          state_nxt_s = ST_LOADING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOADING: begin
        if (err_set_s) begin
          state_nxt_s = ST_IDLE;
        end else if (commit_s) begin
          state_nxt_s = ST_PENDING;
        end else begin
          state_nxt_s = ST_LOADING;
        end
      end
      ST_PENDING: begin
        if (swap_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Load FSM per-cycle decisions: write, counter, commit, error and swap.
  // A commit in LOADING cannot swap in the same cycle; the swap needs PENDING.
  always_comb begin
    cfg_acc_s = i_cfg_valid && o_cfg_ready;
    we_s      = 1'b0;
    err_set_s = 1'b0;
    commit_s  = 1'b0;
    cnt_nxt_s = cfg_cnt_r;
    if (cfg_acc_s) begin
      if (cfg_cnt_r == BEAT_OVF) begin
        // Beat past the end of the table: dropped.
        err_set_s = 1'b1;
        cnt_nxt_s = '0;
      end else if (i_cfg_last) begin
        we_s      = 1'b1;
        cnt_nxt_s = '0;
        if (cfg_cnt_r == LAST_BEAT) begin
          commit_s = 1'b1;
        end else begin
          err_set_s = 1'b1;
        end
      end else begin
        we_s      = 1'b1;
        cnt_nxt_s = cfg_cnt_r + AW'(1);
      end
    end else begin
      cnt_nxt_s = cfg_cnt_r;
    end
    swap_s = (state_r == ST_PENDING) && i_valid && i_sof;
  end

  // Config counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_cnt_r     <= '0;
      o_cfg_err     <= 1'b0;
      o_cfg_pending <= 1'b0;
      o_cfg_ready   <= 1'b1;
      o_active_bank <= 1'b0;
    end else begin
      cfg_cnt_r     <= cnt_nxt_s;
      o_cfg_pending <= (state_nxt_s == ST_PENDING);
      o_cfg_ready   <= (state_nxt_s != ST_PENDING);
      if (swap_s) begin
        o_active_bank <= ~o_active_bank;
      end
      // A new error outranks a simultaneous clear.
      if (err_set_s) begin
        o_cfg_err <= 1'b1;
      end else if (i_cfg_err_clr) begin
        o_cfg_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lut3d_dbuf_fetch.sv
// Directed testbench for lut3d_dbuf_fetch with GS=17, PPC=2, LUT_CD=10.
module tb_lut3d_dbuf_fetch;

  localparam int GS    = 17;
  localparam int CD    = 10;
  localparam int PPC   = 2;
  localparam int IB    = 5;
  localparam int EW    = 3 * CD;
  localparam int DEPTH = GS * GS * GS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_valid = 1'b0;
  logic                  i_sof = 1'b0;
  logic [PPC*IB-1:0]     i_idx_r = '0;
  logic [PPC*IB-1:0]     i_idx_g = '0;
  logic [PPC*IB-1:0]     i_idx_b = '0;
  logic                  o_valid;
  logic [PPC*8*EW-1:0]   o_nbr;
  logic [EW-1:0]         i_cfg_data = '0;
  logic                  i_cfg_valid = 1'b0;
  logic                  o_cfg_ready;
  logic                  i_cfg_last = 1'b0;
  logic                  i_cfg_err_clr = 1'b0;
  logic                  o_cfg_err;
  logic                  o_cfg_pending;
  logic                  o_active_bank;

  int n_checks = 0;
  int n_fail   = 0;

  lut3d_dbuf_fetch #(.GS(GS), .LUT_CD(CD), .PPC(PPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_sof         (i_sof),
    .i_idx_r       (i_idx_r),
    .i_idx_g       (i_idx_g),
    .i_idx_b       (i_idx_b),
    .o_valid       (o_valid),
    .o_nbr         (o_nbr),
    .i_cfg_data    (i_cfg_data),
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_last    (i_cfg_last),
    .i_cfg_err_clr (i_cfg_err_clr),
    .o_cfg_err     (o_cfg_err),
    .o_cfg_pending (o_cfg_pending),
    .o_active_bank (o_active_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entry packed {B,G,R}; mode 0 identity, mode 1 component-wise inverted.
  function automatic logic [EW-1:0] entry(input int mode, input int r, input int g, input int b);
    if (mode == 0) return {10'(b), 10'(g), 10'(r)};
    else           return {10'(1023 - b), 10'(1023 - g), 10'(1023 - r)};
  endfunction

  function automatic logic [EW-1:0] nbr(input int p, input int k);
    return o_nbr[(p*8+k)*EW +: EW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int p, input int r, input int g, input int b);
    i_idx_r[p*IB +: IB] = IB'(r);
    i_idx_g[p*IB +: IB] = IB'(g);
    i_idx_b[p*IB +: IB] = IB'(b);
  endtask

  // Streams nbeats config beats (beat n carries the entry for raster address n).
  // Optionally raises a sof lookup beat and/or err_clr on the final beat.
  task automatic load(input int mode, input int nbeats, input int last_at,
                      input bit sof_last, input bit clr_last);
    for (int n = 0; n < nbeats; n++) begin
      i_cfg_valid = 1'b1;
      i_cfg_data  = entry(mode, n % GS, (n / GS) % GS, n / (GS * GS));
      i_cfg_last  = (n == last_at);
      if (n == nbeats - 1) begin
        i_cfg_err_clr = clr_last;
        i_valid = sof_last;
        i_sof   = sof_last;
      end
      tick();
    end
    i_cfg_valid   = 1'b0;
    i_cfg_last    = 1'b0;
    i_cfg_err_clr = 1'b0;
    i_valid       = 1'b0;
    i_sof         = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},   {63'd0, o_valid},       64'd0);
    check({tag, "_nbr"},     {63'd0, |o_nbr},        64'd0);
    check({tag, "_ready"},   {63'd0, o_cfg_ready},   64'd1);
    check({tag, "_err"},     {63'd0, o_cfg_err},     64'd0);
    check({tag, "_pending"}, {63'd0, o_cfg_pending}, 64'd0);
    check({tag, "_bank"},    {63'd0, o_active_bank}, 64'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // Identity LUT into the shadow bank
    load(0, DEPTH, DEPTH - 1, 1'b0, 1'b0);
    check("ld_a_pending", {63'd0, o_cfg_pending}, 64'd1);
    check("ld_a_ready",   {63'd0, o_cfg_ready},   64'd0);
    check("ld_a_bank",    {63'd0, o_active_bank}, 64'd0);
    check("ld_a_err",     {63'd0, o_cfg_err},     64'd0);

    // Backpressure: junk beats offered while pending must not be taken
    i_cfg_valid = 1'b1;
    i_cfg_data  = 30'h3FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", {63'd0, o_cfg_ready}, 64'd0);
    end

    // Swap on sof; pixel 0 (3,5,7), pixel 1 (0,0,0)
    set_pix(0, 3, 5, 7);
    set_pix(1, 0, 0, 0);
    i_valid = 1'b1;
    i_sof   = 1'b1;
    tick();
    check("swap_bank",    {63'd0, o_active_bank}, 64'd1);
    check("swap_pending", {63'd0, o_cfg_pending}, 64'd0);
    check("swap_ready",   {63'd0, o_cfg_ready},   64'd1);
    check("lat_not_1",    {63'd0, o_valid},       64'd0);
    i_cfg_valid = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    tick();
    check("lat_2_valid", {63'd0, o_valid}, 64'd1);
    check("id_p0_k0", 64'(nbr(0, 0)), 64'({10'd7, 10'd5, 10'd3}));
    check("id_p0_k7", 64'(nbr(0, 7)), 64'({10'd8, 10'd6, 10'd4}));
    check("bp_p1_k0", 64'(nbr(1, 0)), 64'({10'd0, 10'd0, 10'd0}));
    check("id_p1_k7", 64'(nbr(1, 7)), 64'({10'd1, 10'd1, 10'd1}));

    // Clamping; pixel 1 index r=31 is out of range
    set_pix(0, 16, 16, 15);
    set_pix(1, 31, 9, 0);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    check("cl_valid", {63'd0, o_valid}, 64'd1);
    check("cl_p0_k1", 64'(nbr(0, 1)), 64'({10'd15, 10'd16, 10'd16}));
    check("cl_p0_k7", 64'(nbr(0, 7)), 64'({10'd16, 10'd16, 10'd16}));
    check("cl_p1_k0", 64'(nbr(1, 0)), 64'({10'd0, 10'd9, 10'd16}));
    check("cl_p1_k6", 64'(nbr(1, 6)), 64'({10'd1, 10'd10, 10'd16}));
    tick();
    check("hold_valid", {63'd0, o_valid}, 64'd0);
    check("hold_p0_k1", 64'(nbr(0, 1)), 64'({10'd15, 10'd16, 10'd16}));

    // Inverted LUT into bank 0; a sof on the commit beat must not swap
    set_pix(0, 1, 2, 3);
    set_pix(1, 5, 6, 7);
    load(1, DEPTH, DEPTH - 1, 1'b1, 1'b0);
    check("ldb_pending", {63'd0, o_cfg_pending}, 64'd1);
    check("ldb_bank",    {63'd0, o_active_bank}, 64'd1);
    tick();
    check("cs_p0_a", 64'(nbr(0, 0)), 64'({10'd3, 10'd2, 10'd1}));
    check("cs_p1_a", 64'(nbr(1, 0)), 64'({10'd7, 10'd6, 10'd5}));
    // Non-sof beat, then sof beat, then a following beat
    i_valid = 1'b1;
    i_sof   = 1'b0;
    tick();
    set_pix(0, 4, 4, 4);
    i_sof = 1'b1;
    tick();
    check("sw2_bank",    {63'd0, o_active_bank}, 64'd0);
    check("sw2_pending", {63'd0, o_cfg_pending}, 64'd0);
    check("pre_sof_a",   64'(nbr(0, 0)), 64'({10'd3, 10'd2, 10'd1}));
    set_pix(0, 6, 6, 6);
    set_pix(1, 0, 0, 0);
    i_sof = 1'b0;
    tick();
    i_valid = 1'b0;
    check("sof_beat_b", 64'(nbr(0, 0)), 64'({10'd1019, 10'd1019, 10'd1019}));
    tick();
    check("post_b_k7", 64'(nbr(0, 7)), 64'({10'd1016, 10'd1016, 10'd1016}));
    check("post_b_p1", 64'(nbr(1, 0)), 64'({10'd1023, 10'd1023, 10'd1023}));

    // Early last on beat 100
    load(0, 101, 100, 1'b0, 1'b0);
    check("e100_err",     {63'd0, o_cfg_err},     64'd1);
    check("e100_pending", {63'd0, o_cfg_pending}, 64'd0);
    check("e100_bank",    {63'd0, o_active_bank}, 64'd0);
    check("e100_ready",   {63'd0, o_cfg_ready},   64'd1);
    i_cfg_err_clr = 1'b1;
    tick();
    i_cfg_err_clr = 1'b0;
    check("clr_err", {63'd0, o_cfg_err}, 64'd0);
    // New error together with clear: error stays set
    load(0, 6, 5, 1'b0, 1'b1);
    check("err_wins", {63'd0, o_cfg_err}, 64'd1);
    i_cfg_err_clr = 1'b1;
    tick();
    i_cfg_err_clr = 1'b0;
    // Beat beyond the end without last
    load(0, DEPTH + 1, -1, 1'b0, 1'b0);
    check("ovf_err",     {63'd0, o_cfg_err},     64'd1);
    check("ovf_pending", {63'd0, o_cfg_pending}, 64'd0);
    i_cfg_err_clr = 1'b1;
    tick();
    i_cfg_err_clr = 1'b0;
    // Full reload succeeds; lookups still use bank 0 (inverted)
    load(0, DEPTH, DEPTH - 1, 1'b0, 1'b0);
    check("rl_pending", {63'd0, o_cfg_pending}, 64'd1);
    check("rl_err",     {63'd0, o_cfg_err},     64'd0);
    set_pix(0, 1, 2, 3);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    check("rl_still_b", 64'(nbr(0, 0)), 64'({10'd1020, 10'd1021, 10'd1022}));

    // Reset with a pending swap
    rst = 1'b1;
    #2;
    check_reset("rst_pend");
    tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a load, at beat 2000
    load(1, 2000, -1, 1'b0, 1'b0);
    i_cfg_valid = 1'b1;
    i_cfg_data  = entry(1, 0, 0, 0);
    #1;
    rst = 1'b1;
    #2;
    check_reset("rst_load");
    tick();
    i_cfg_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Fresh full load and sof
    load(0, DEPTH, DEPTH - 1, 1'b0, 1'b0);
    check("fr_pending", {63'd0, o_cfg_pending}, 64'd1);
    check("fr_err",     {63'd0, o_cfg_err},     64'd0);
    set_pix(0, 1, 2, 3);
    set_pix(1, 3, 5, 7);
    i_valid = 1'b1;
    i_sof   = 1'b1;
    tick();
    i_valid = 1'b0;
    i_sof   = 1'b0;
    check("fr_bank", {63'd0, o_active_bank}, 64'd1);
    tick();
    check("fr_valid", {63'd0, o_valid}, 64'd1);
    check("fr_p0_k0", 64'(nbr(0, 0)), 64'({10'd3, 10'd2, 10'd1}));
    check("fr_p1_k7", 64'(nbr(1, 7)), 64'({10'd8, 10'd6, 10'd4}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut3d_dbuf_fetch.md
Name: lut3d_dbuf_fetch

Overview:
- Double-buffered 3D-LUT neighbour fetch for the colour-grading pipeline; successor to the single-bank, fixed two-pixel LUT RAM.
- Per pixel it returns the 8 lattice corners surrounding an (r,g,b) grid index; the downstream trilinear/tetrahedral interpolator consumes them.
- Generalised in grid size, pixels per clock and colour depth. Adds a shadow bank loaded while video streams, a frame-aligned bank swap, config backpressure and load-error detection.

Parameters:
- GS, 33, grid points per axis; GS-1 must be a power of 2, 5..65. Elaboration error otherwise.
- LUT_CD, 10, bits per colour component of a LUT entry.
- PPC, 2, pixels per clock (1..4); each pixel has an independent lookup port.
- IDX_BIT, $clog2(GS), localparam, index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  lookup beat valid.
- i_sof  in  1  start-of-frame, qualified by i_valid.
- i_idx_r  in  PPC*IDX_BIT  red grid index per pixel; pixel p at [p*IDX_BIT +: IDX_BIT].
- i_idx_g  in  PPC*IDX_BIT  green grid index per pixel.
- i_idx_b  in  PPC*IDX_BIT  blue grid index per pixel.
- o_valid  out  1  neighbour data valid.
- o_nbr  out  PPC*8*LUT_CD*3  corner k of pixel p at [(p*8+k)*3*LUT_CD +: 3*LUT_CD]; entry packed {B,G,R}.
- i_cfg_data  in  3*LUT_CD  LUT entry.
- i_cfg_valid  in  1  config beat offered.
- o_cfg_ready  out  1  config beat accepted when valid&&ready.
- i_cfg_last  in  1  final beat of a LUT load, qualified by the handshake.
- i_cfg_err_clr  in  1  clears o_cfg_err.
- o_cfg_err  out  1  sticky load-error flag.
- o_cfg_pending  out  1  a complete shadow LUT is waiting for swap.
- o_active_bank  out  1  bank currently used for lookups.

Behaviour:
- Reset values: o_valid=0, o_nbr=0, o_cfg_ready=1, o_cfg_err=0, o_cfg_pending=0, o_active_bank=0, config counters 0. RAM contents undefined.
- Storage: two banks of GS^3 entries. Internal partitioning is free, e.g. parity-split sub-RAMs, but all 8*PPC corners must be read every cycle with no stalls.
- Lookup:
  - Corner k reads LUT[b+k[2]][g+k[1]][r+k[0]].
  - Any index, input or +1, greater than GS-1 is clamped to GS-1.
  - Latency is exactly 2 cycles, so o_valid(t+2)=i_valid(t).
  - o_nbr holds its last value when o_valid=0.
  - The input index is registered even when i_valid=0.
- Config load:
  - Raster order, r fastest, then g, then b; GS^3 beats go to the inactive bank.
  - Counters advance only on valid&&ready.
  - o_cfg_ready=0 while o_cfg_pending=1.
- Commit:
  - If i_cfg_last arrives on beat GS^3-1, set o_cfg_pending on the next cycle and clear the counters.
  - If i_cfg_last arrives on any other beat: set o_cfg_err, clear the counters, do not set pending. The shadow bank contents are then invalid.
  - If a beat is accepted after beat GS^3-1 without i_cfg_last: set o_cfg_err, drop the beat, clear the counters.
- Swap states:
  - States are IDLE, LOADING and PENDING.
  - IDLE goes to LOADING on the first accepted beat.
  - LOADING goes to PENDING on a good last. On an error it returns to IDLE.
  - PENDING returns to IDLE on the swap cycle.
  - The swap cycle is the first cycle with i_valid&&i_sof while pending. That beat already reads from the new bank.
  - On the swap cycle, o_active_bank toggles and o_cfg_pending clears; both are registered and visible the next cycle.
- Simultaneous events:
  - i_cfg_last commit and i_sof in the same cycle: the swap waits for the next sof.
  - i_cfg_err_clr together with a new error: the error wins.
- Reset mid-load or mid-frame: everything returns to reset values. Bank 0 becomes active and any pending load is discarded.

Test Plan:
- GS=17, PPC=2. Load identity LUT entry(r,g,b)={b,g,r} with last on beat 4912, then sof. Pixel 0 idx (3,5,7): nbr0={7,5,3} and nbr7={8,6,4}, appearing 2 cycles later with o_valid.
- Clamp: idx (16,16,15) -> nbr1={15,16,16} and nbr7={16,16,16}. Pixel 1 looked up simultaneously with independent values.
- Swap: load LUT B (entries inverted) during a frame. Lookups keep returning A until the sof beat; the sof beat and later beats return B. o_active_bank flips and o_cfg_pending drops.
- Backpressure: with pending=1, hold i_cfg_valid high. o_cfg_ready=0, nothing is written, and ready returns to 1 the cycle after the swap.
- Error: i_cfg_last on beat 100 -> o_cfg_err=1, no pending, active bank unchanged. i_cfg_err_clr -> err=0. A full reload then succeeds.
- Reset asserted at beat 2000 of a load with a pending swap -> all outputs at reset values; a fresh full load and sof work correctly.
